// File: rtl/shader_pkg.sv
// Shared shader constants: datapath widths, opcode field layout and opcode values
// used by both the fetch unit and the core decoder.
package shader_pkg;

    localparam int unsigned INSTR_W    = 16;
    localparam int unsigned ADDR_W     = 4;
    localparam int unsigned IMEM_DEPTH = 16;
    localparam int unsigned FIFO_DEPTH = 4;

    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned OPC_W   = OPC_MSB - OPC_LSB + 1;

    localparam logic [OPC_W-1:0] OPCODE_NOP  = 4'h0;
    localparam logic [OPC_W-1:0] OPCODE_ADD  = 4'h1;
    localparam logic [OPC_W-1:0] OPCODE_SUB  = 4'h2;
    localparam logic [OPC_W-1:0] OPCODE_AND  = 4'h3;
    localparam logic [OPC_W-1:0] OPCODE_OR   = 4'h4;
    localparam logic [OPC_W-1:0] OPCODE_XOR  = 4'h5;
    localparam logic [OPC_W-1:0] OPCODE_LDI  = 4'h6;
    localparam logic [OPC_W-1:0] OPCODE_LD   = 4'h7;
    localparam logic [OPC_W-1:0] OPCODE_ST   = 4'h8;
    localparam logic [OPC_W-1:0] OPCODE_BEQ  = 4'h9;
    localparam logic [OPC_W-1:0] OPCODE_JMP  = 4'hA;
    localparam logic [OPC_W-1:0] OPCODE_HALT = 4'hF;

    // One prefetch buffer entry: instruction word tagged with its fetch PC.
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic is_halt(input logic [INSTR_W-1:0] word);
        return word[OPC_MSB:OPC_LSB] == OPCODE_HALT;
    endfunction

    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return (pc == ADDR_W'(IMEM_DEPTH - 1)) ? '0 : pc + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/shader_fetch_fifo.sv
// Prefetch buffer: synchronous FIFO with flush; the head entry is presented
// directly from storage so it is visible the cycle after it is written.
module shader_fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 20
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   full_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Flush wins over any same-cycle push or pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/shader_fetch_unit.sv
// Shader instruction fetch: PC generation, one-deep read pipeline into a
// credit-guarded prefetch FIFO, branch redirect flush and HALT stop.
module shader_fetch_unit
    import shader_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               halted
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CRD_W = CNT_W + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              inflight_q, inflight_d;
    logic              halt_seen_q, halt_seen_d;
    logic              halted_q, halted_d;

    logic              issue, push, pop;
    logic [CRD_W-1:0]  credit_used;
    logic [CNT_W-1:0]  fifo_count, count_next;
    logic              fifo_empty, fifo_full;
    fetch_entry_t      push_entry, head_entry;

    // Issue only when the buffer plus the in-flight read still leave room.
    always_comb begin
        pop         = instr_valid && instr_ready;
        credit_used = CRD_W'(fifo_count) + CRD_W'(inflight_q) - CRD_W'(pop);
        issue       = !reset && !halt_seen_q && !redirect_valid
                      && (credit_used < CRD_W'(FIFO_DEPTH));
        push        = inflight_q && !redirect_valid && !halt_seen_q;
        push_entry  = '{pc: fetch_pc_q, instr: imem_rdata};

        pc_d        = pc_q;
        fetch_pc_d  = fetch_pc_q;
        inflight_d  = issue;
        halt_seen_d = halt_seen_q;
        if (redirect_valid) begin
            pc_d        = redirect_pc;
            halt_seen_d = 1'b0;
        end else begin
            if (issue) begin
                pc_d       = pc_inc(pc_q);
                fetch_pc_d = pc_q;
            end
            if (push && is_halt(imem_rdata)) begin
                halt_seen_d = 1'b1;
            end
        end

        count_next = redirect_valid ? '0
                   : fifo_count + CNT_W'(push) - CNT_W'(pop);
        halted_d   = halt_seen_d && (count_next == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= '0;
            fetch_pc_q  <= '0;
            inflight_q  <= 1'b0;
            halt_seen_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            fetch_pc_q  <= fetch_pc_d;
            inflight_q  <= inflight_d;
            halt_seen_q <= halt_seen_d;
            halted_q    <= halted_d;
        end
    end

    shader_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .rdata_o (head_entry),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    no_overflow: assert property (@(posedge clk) disable iff (reset)
                                  !(fifo_full && push && !pop));

    assign imem_en     = issue;
    assign imem_addr   = pc_q;
    assign instr       = head_entry.instr;
    assign instr_pc    = head_entry.pc;
    assign instr_valid = !fifo_empty;
    assign halted      = halted_q;

endmodule

// File: tb/tb_shader_fetch_unit.sv
// Bench for shader_fetch_unit: instruction-stream scoreboard plus directed
// latency, stall, wrap, redirect, HALT and reset scenarios.
module tb_shader_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_en;
    logic [3:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic [3:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [3:0]  redirect_pc;
    logic        halted;

    shader_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
    );

    int checks   = 0;
    int failures = 0;

    logic [15:0] imem [0:15];
    logic        en_s;
    logic [3:0]  addr_s;

    // Expected-stream model: next PC to deliver, whether delivery is live, halted flag.
    logic [3:0]  exp_pc;
    logic        exp_live;
    logic        hlt;
    int          pops;
    int          issues;
    logic [3:0]  popped_pc [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Synchronous instruction memory: address captured mid-cycle, data next cycle.
    always @(negedge clk) begin
        en_s   = imem_en;
        addr_s = imem_addr;
    end
    always @(posedge clk) begin
        if (en_s === 1'b1) imem_rdata <= imem[addr_s];
    end

    // Compare process: every valid head must be the next word of the expected stream.
    always @(negedge clk) begin
        if (reset) begin
            exp_pc   = 4'd0;
            exp_live = 1'b1;
            hlt      = 1'b0;
            pops     = 0;
            issues   = 0;
            popped_pc.delete();
        end else begin
            if (imem_en) issues++;
            chk("sb_halted", halted, hlt);
            if (hlt) chk("sb_halted_no_fetch", imem_en, 0);
            if (instr_valid) begin
                chk("sb_valid_allowed", exp_live, 1);
                chk("sb_instr", instr, imem[exp_pc]);
                chk("sb_pc", instr_pc, exp_pc);
                if (instr_ready) begin
                    pops++;
                    popped_pc.push_back(instr_pc);
                    if (imem[exp_pc][15:12] == 4'hF) begin
                        exp_live = 1'b0;
                        hlt      = 1'b1;
                    end
                    exp_pc = exp_pc + 4'd1;
                end
            end
            if (redirect_valid) begin
                exp_pc   = redirect_pc;
                exp_live = 1'b1;
                hlt      = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset for a few cycles, loading imem meanwhile; release lands at the start of cycle 0.
    task automatic do_reset(input int halt_idx);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 4'd0;
        instr_ready    = 1'b0;
        tick();
        for (int k = 0; k < 16; k++) imem[k] = 16'h1000 + 16'(k);
        if (halt_idx >= 0) imem[halt_idx] = 16'hF000;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 4'd0;

        // 1: reset values, first-fetch latency, back-to-back delivery
        do_reset(-1);
        reset = 1'b1;
        #1;
        chk("rst_imem_en", imem_en, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_halted", halted, 0);
        tick();
        reset = 1'b0;
        instr_ready = 1'b1;
        #1;
        chk("t1_en_c0", imem_en, 1);
        chk("t1_addr_c0", imem_addr, 0);
        chk("t1_valid_c0", instr_valid, 0);
        tick(); #1;
        chk("t1_valid_c1", instr_valid, 0);
        tick(); #1;
        chk("t1_valid_c2", instr_valid, 1);
        chk("t1_instr_c2", instr, 16'h1000);
        chk("t1_pc_c2", instr_pc, 0);
        for (int i = 1; i < 10; i++) begin
            tick(); #1;
            chk("t1_stream_valid", instr_valid, 1);
            chk("t1_stream_instr", instr, 16'h1000 + 16'(i));
        end

        // 2: consumer stall saturates the buffer, then drains without loss
        do_reset(-1);
        repeat (11) tick();
        #1;
        chk("t2_issues", issues, 4);
        chk("t2_en_stalled", imem_en, 0);
        chk("t2_head_valid", instr_valid, 1);
        chk("t2_head_instr", instr, 16'h1000);
        instr_ready = 1'b1;
        for (int i = 1; i < 6; i++) begin
            tick(); #1;
            chk("t2_drain_valid", instr_valid, 1);
            chk("t2_drain_instr", instr, 16'h1000 + 16'(i));
        end

        // 3: PC wraps 15 -> 0
        do_reset(-1);
        instr_ready = 1'b1;
        for (int c = 0; c < 60 && pops < 20; c++) tick();
        #1;
        chk("t3_pops_reached", (pops >= 20) ? 1 : 0, 1);
        chk("t3_pc15", popped_pc[15], 15);
        chk("t3_pc16_wrap", popped_pc[16], 0);
        chk("t3_pc19", popped_pc[19], 3);

        // 4: redirect with 3 buffered entries and one read in flight
        do_reset(-1);
        repeat (4) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 4'd9;
        #1;
        chk("t4_valid_before", instr_valid, 1);
        chk("t4_no_issue_redirect", imem_en, 0);
        tick();
        redirect_valid = 1'b0;
        instr_ready    = 1'b1;
        #1;
        chk("t4_en_t1", imem_en, 1);
        chk("t4_addr_t1", imem_addr, 9);
        chk("t4_valid_t1", instr_valid, 0);
        tick(); #1;
        chk("t4_valid_t2", instr_valid, 0);
        tick(); #1;
        chk("t4_valid_t3", instr_valid, 1);
        chk("t4_instr_t3", instr, 16'h1009);
        chk("t4_pc_t3", instr_pc, 9);
        tick(); #1;
        chk("t4_instr_t4", instr, 16'h100A);

        // 5: HALT at word 5, then redirect resumes
        do_reset(5);
        instr_ready = 1'b1;
        repeat (7) tick();
        #1;
        chk("t5_halt_head", instr, 16'hF000);
        chk("t5_halted_c7", halted, 0);
        chk("t5_en_c7", imem_en, 0);
        tick(); #1;
        chk("t5_halted_c8", halted, 1);
        chk("t5_valid_c8", instr_valid, 0);
        chk("t5_pops_c8", pops, 6);
        repeat (6) tick();
        #1;
        chk("t5_still_halted", halted, 1);
        chk("t5_pops_late", pops, 6);
        chk("t5_en_late", imem_en, 0);
        redirect_valid = 1'b1;
        redirect_pc    = 4'd0;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("t5_unhalted", halted, 0);
        chk("t5_resume_en", imem_en, 1);
        chk("t5_resume_addr", imem_addr, 0);
        tick(); tick(); #1;
        chk("t5_resume_valid", instr_valid, 1);
        chk("t5_resume_instr", instr, 16'h1000);

        // 6: asynchronous reset with 2 entries buffered
        do_reset(-1);
        repeat (3) tick();
        #1;
        chk("t6_buffered", instr_valid, 1);
        reset = 1'b1;
        #1;
        chk("t6_rst_en", imem_en, 0);
        chk("t6_rst_addr", imem_addr, 0);
        chk("t6_rst_instr", instr, 0);
        chk("t6_rst_pc", instr_pc, 0);
        chk("t6_rst_valid", instr_valid, 0);
        chk("t6_rst_halted", halted, 0);
        tick(); tick();
        reset       = 1'b0;
        instr_ready = 1'b1;
        #1;
        chk("t6_restart_addr", imem_addr, 0);
        tick(); tick(); #1;
        chk("t6_restart_valid", instr_valid, 1);
        chk("t6_restart_instr", instr, 16'h1000);
        chk("t6_restart_pc", instr_pc, 0);
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
